// File: rtl/ibex_rf_pkg.sv
// Shared types and helpers for the multi-port flop register file.
package ibex_rf_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

  localparam int unsigned RF_MAX_RD_PORTS = 4;
  localparam int unsigned RF_MAX_WR_PORTS = 2;
  localparam int unsigned RF_RAW_ADDR_W   = 5;

  function automatic int unsigned rf_addr_width(input bit rv32e);
    return rv32e ? 32'd4 : 32'd5;
  endfunction

endpackage

// File: rtl/ibex_rf_read_port.sv
// One read port: word select, r0 / shadow-r0 handling and, with IBEX_RF_BYPASS_EN,
// forwarding from the write sample stage.
module ibex_rf_read_port
  import ibex_rf_pkg::*;
#(
  parameter int unsigned          AddrWidth         = 5,
  parameter int unsigned          DataWidth         = 32,
`ifdef IBEX_RF_BYPASS_EN
  parameter int unsigned          NumWritePorts     = 1,
`endif
  parameter bit                   DummyInstructions = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
  input  logic [AddrWidth-1:0]                          raddr_i,
  input  logic                                          dummy_instr_id_i,
  input  logic [(2**AddrWidth)-1:0][DataWidth-1:0]      mem_i,
  input  logic [DataWidth-1:0]                          shadow_r0_i,
`ifdef IBEX_RF_BYPASS_EN
  input  logic [NumWritePorts-1:0]                      stage_valid_i,
  input  logic [NumWritePorts-1:0][AddrWidth-1:0]       stage_addr_i,
  input  logic [NumWritePorts-1:0][DataWidth-1:0]       stage_data_i,
`endif
  output logic [DataWidth-1:0]                          rdata_o
);

  logic use_shadow;
  logic unused_shadow;

  assign use_shadow    = DummyInstructions & dummy_instr_id_i;
  assign unused_shadow = ^{shadow_r0_i, dummy_instr_id_i};

  // Port 0's stage entry is visited last so it wins when both entries match.
  always_comb begin
    rdata_o = mem_i[raddr_i];
    if (raddr_i == '0) begin
      rdata_o = use_shadow ? shadow_r0_i : WordZeroVal;
    end
`ifdef IBEX_RF_BYPASS_EN
    if ((raddr_i != '0) || use_shadow) begin
      for (int w = int'(NumWritePorts) - 1; w >= 0; w--) begin
        if (stage_valid_i[w] && (stage_addr_i[w] == raddr_i)) begin
          rdata_o = stage_data_i[w];
        end
      end
    end
`endif
  end

endmodule

// File: rtl/ibex_register_file_mp.sv
// Multi-port flop register file with a one-stage write sample register and a hardware
// scrub FSM. Define IBEX_RF_BYPASS_EN to forward staged write data to the read ports.
module ibex_register_file_mp
  import ibex_rf_pkg::*;
#(
  parameter bit                   RV32E             = 1'b0,
  parameter int unsigned          DataWidth         = 32,
  parameter int unsigned          NumReadPorts      = 2,
  parameter int unsigned          NumWritePorts     = 1,
  parameter bit                   DummyInstructions = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
  input  logic                                  clk_int,
  input  logic                                  rst_ni,
  input  logic                                  dummy_instr_id_i,
  input  logic                                  scrub_req_i,
  input  logic [NumReadPorts*RF_RAW_ADDR_W-1:0]  raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]      rdata_o,
  input  logic [NumWritePorts*RF_RAW_ADDR_W-1:0] waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0]     wdata_i,
  input  logic [NumWritePorts-1:0]               we_i,
  output logic                                  ready_o,
  output logic                                  err_o
);

  localparam int unsigned AddrWidth = rf_addr_width(RV32E);
  localparam int unsigned NumWords  = 32'(1) << AddrWidth;

  if ((NumReadPorts < 1) || (NumReadPorts > RF_MAX_RD_PORTS)) begin : g_bad_rd_ports
    $error("ibex_register_file_mp: NumReadPorts must be in 1..4");
  end
  if ((NumWritePorts < 1) || (NumWritePorts > RF_MAX_WR_PORTS)) begin : g_bad_wr_ports
    $error("ibex_register_file_mp: NumWritePorts must be in 1..2");
  end

  rf_state_e                                state_q;
  logic [AddrWidth-1:0]                     cnt_q;
  logic                                     ready_q;
  logic                                     err_q, err_d;
  logic                                     collide;
  logic [DataWidth-1:0]                     shadow_q;
  logic [DataWidth-1:0]                     mem_q [NumWords-1:1];
  logic [NumWords-1:0][DataWidth-1:0]       mem_rd;
  logic [NumWritePorts-1:0]                 stg_valid_d, stg_valid_q;
  logic [NumWritePorts-1:0][AddrWidth-1:0]  stg_addr_d, stg_addr_q;
  logic [NumWritePorts-1:0][DataWidth-1:0]  stg_data_d, stg_data_q;
  logic                                     unused_addr;

  assign ready_o     = ready_q;
  assign err_o       = err_q;
  assign unused_addr = ^{raddr_i, waddr_i};

  // Scrub FSM: words 1..NumWords-1 are cleared one per cycle; word 0 is never stored.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_CLEAR;
      cnt_q   <= AddrWidth'(1);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          cnt_q <= cnt_q + AddrWidth'(1);
          if (cnt_q == AddrWidth'(NumWords - 1)) begin
            state_q <= RF_READY;
            ready_q <= 1'b1;
          end
        end
        RF_READY: begin
          if (scrub_req_i) begin
            state_q <= RF_CLEAR;
            cnt_q   <= AddrWidth'(1);
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= RF_CLEAR;
          cnt_q   <= AddrWidth'(1);
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  if (NumWritePorts == 2) begin : g_collide
    assign collide = we_i[0] & we_i[1] &
                     (waddr_i[0 +: AddrWidth] == waddr_i[RF_RAW_ADDR_W +: AddrWidth]) &
                     (waddr_i[0 +: AddrWidth] != '0);
  end else begin : g_no_collide
    assign collide = 1'b0;
  end

  // Write sample stage request decode; port 1 yields to port 0 on the same address.
  always_comb begin
    stg_valid_d = '0;
    stg_addr_d  = '0;
    stg_data_d  = '0;
    for (int w = 0; w < int'(NumWritePorts); w++) begin
      stg_addr_d[w]  = waddr_i[RF_RAW_ADDR_W*w +: AddrWidth];
      stg_data_d[w]  = wdata_i[DataWidth*w +: DataWidth];
      stg_valid_d[w] = we_i[w] & ready_q &
                       ((stg_addr_d[w] != '0) | (DummyInstructions & dummy_instr_id_i));
    end
    if ((NumWritePorts == 2) && stg_valid_d[0] &&
        (stg_addr_d[0] == stg_addr_d[NumWritePorts-1])) begin
      stg_valid_d[NumWritePorts-1] = 1'b0;
    end
    err_d = (~ready_q & (|we_i)) | collide;
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_valid_q <= '0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      err_q       <= 1'b0;
      shadow_q    <= WordZeroVal;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      err_q       <= err_d;
      for (int w = int'(NumWritePorts) - 1; w >= 0; w--) begin
        if (DummyInstructions && stg_valid_q[w] && (stg_addr_q[w] == '0)) begin
          shadow_q <= stg_data_q[w];
        end
      end
    end
  end

  // Array has no reset; a scrub write to the same word overrides a stage commit.
  always_ff @(posedge clk_int) begin
    for (int w = int'(NumWritePorts) - 1; w >= 0; w--) begin
      if (stg_valid_q[w] && (stg_addr_q[w] != '0)) begin
        mem_q[stg_addr_q[w]] <= stg_data_q[w];
      end
    end
    if ((state_q == RF_CLEAR) && (cnt_q != '0)) begin
      mem_q[cnt_q] <= WordZeroVal;
    end
  end

  always_comb begin
    mem_rd    = '0;
    mem_rd[0] = WordZeroVal;
    for (int i = 1; i < int'(NumWords); i++) begin
      mem_rd[i] = mem_q[i];
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    ibex_rf_read_port #(
      .AddrWidth         (AddrWidth),
      .DataWidth         (DataWidth),
`ifdef IBEX_RF_BYPASS_EN
      .NumWritePorts     (NumWritePorts),
`endif
      .DummyInstructions (DummyInstructions),
      .WordZeroVal       (WordZeroVal)
    ) u_rd (
      .raddr_i          (raddr_i[RF_RAW_ADDR_W*p +: AddrWidth]),
      .dummy_instr_id_i (dummy_instr_id_i),
      .mem_i            (mem_rd),
      .shadow_r0_i      (shadow_q),
`ifdef IBEX_RF_BYPASS_EN
      .stage_valid_i    (stg_valid_q),
      .stage_addr_i     (stg_addr_q),
      .stage_data_i     (stg_data_q),
`endif
      .rdata_o          (rdata_o[DataWidth*p +: DataWidth])
    );
  end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Bench for ibex_register_file_mp (2 read, 2 write ports, shadow r0 enabled).
module tb_ibex_register_file_mp;

  localparam int unsigned DW     = 32;
  localparam int unsigned NR     = 2;
  localparam int unsigned NW     = 2;
  localparam int          NWORDS = 32;
`ifdef IBEX_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk_int     = 1'b0;
  logic               rst_ni      = 1'b0;
  logic               dummy_instr = 1'b0;
  logic               scrub_req   = 1'b0;
  logic [NR*5-1:0]    raddr       = '0;
  logic [NR*DW-1:0]   rdata;
  logic [NW*5-1:0]    waddr       = '0;
  logic [NW*DW-1:0]   wdata       = '0;
  logic [NW-1:0]      we          = '0;
  logic               ready;
  logic               err;

  always #5 clk_int = ~clk_int;

  ibex_register_file_mp #(
    .RV32E             (1'b0),
    .DataWidth         (DW),
    .NumReadPorts      (NR),
    .NumWritePorts     (NW),
    .DummyInstructions (1'b1),
    .WordZeroVal       (32'h0)
  ) dut (
    .clk_int          (clk_int),
    .rst_ni           (rst_ni),
    .dummy_instr_id_i (dummy_instr),
    .scrub_req_i      (scrub_req),
    .raddr_i          (raddr),
    .rdata_o          (rdata),
    .waddr_i          (waddr),
    .wdata_i          (wdata),
    .we_i             (we),
    .ready_o          (ready),
    .err_o            (err)
  );

  // Reference model: architectural words, shadow r0, pending writes and scrub progress.
  logic [31:0] m_mem [NWORDS];
  logic [31:0] m_shadow;
  bit          m_rdy;
  int          m_left;
  bit          m_err;
  bit          st_v [NW];
  logic [4:0]  st_a [NW];
  logic [31:0] st_d [NW];

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic d);
    logic [31:0] v;
    if (a == 5'd0) v = d ? m_shadow : 32'h0;
    else v = m_mem[a];
    if (BYP && (a != 5'd0 || d)) begin
      for (int w = int'(NW) - 1; w >= 0; w--)
        if (st_v[w] && st_a[w] == a) v = st_d[w];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NWORDS; i++) m_mem[i] = 32'h0;
    m_shadow = 32'h0;
    m_rdy    = 1'b0;
    m_left   = NWORDS - 1;
    m_err    = 1'b0;
    for (int w = 0; w < int'(NW); w++) begin
      st_v[w] = 1'b0; st_a[w] = 5'd0; st_d[w] = 32'h0;
    end
  endtask

  task automatic model_edge();
    logic [4:0] a [NW];
    bit nv [NW];
    bit nerr;
    for (int w = int'(NW) - 1; w >= 0; w--) begin
      if (st_v[w]) begin
        if (st_a[w] == 5'd0) m_shadow = st_d[w];
        else m_mem[st_a[w]] = st_d[w];
      end
    end
    nerr = 1'b0;
    for (int w = 0; w < int'(NW); w++) begin
      a[w]  = waddr[5*w +: 5];
      nv[w] = we[w] && m_rdy && (a[w] != 5'd0 || dummy_instr);
      if (we[w] && !m_rdy) nerr = 1'b1;
    end
    if (we[0] && we[1] && a[0] == a[1] && a[0] != 5'd0) nerr = 1'b1;
    if (nv[0] && nv[1] && a[0] == a[1]) nv[1] = 1'b0;
    for (int w = 0; w < int'(NW); w++) begin
      st_v[w] = nv[w]; st_a[w] = a[w]; st_d[w] = wdata[DW*w +: DW];
    end
    if (m_rdy) begin
      if (scrub_req) begin
        m_rdy  = 1'b0;
        m_left = NWORDS - 1;
        for (int i = 0; i < NWORDS; i++) m_mem[i] = 32'h0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1'b1;
        for (int i = 0; i < NWORDS; i++) m_mem[i] = 32'h0;
      end
    end
    m_err = nerr;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_int);
    #1;
    chk("ready_o", 32'(ready), 32'(m_rdy));
    chk("err_o", 32'(err), 32'(m_err));
    if (m_rdy) begin
      for (int p = 0; p < int'(NR); p++)
        chk($sformatf("rdata%0d x%0d", p, raddr[5*p +: 5]), rdata[DW*p +: DW],
            m_read(raddr[5*p +: 5], dummy_instr));
    end
  endtask

  task automatic idle();
    we        = '0;
    scrub_req = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    raddr[5*p +: 5] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p]            = 1'b1;
    waddr[5*p +: 5]  = a;
    wdata[DW*p +: DW] = d;
  endtask

  task automatic count_low(input int start, input string name);
    int low;
    low = start;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ready) break;
      low++;
    end
    chk(name, 32'(low), 32'd31);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5'd5,  32'hCAFEF00D, 32'hCAFEF00D};
    tbl[1] = '{5'd0,  32'h12345678, 32'h00000000};
    tbl[2] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[3] = '{5'd1,  32'h00000001, 32'h00000001};
    tbl[4] = '{5'd16, 32'hA5A5A5A5, 32'hA5A5A5A5};

    // Reset and initial scrub
    idle();
    model_reset();
    repeat (2) @(posedge clk_int);
    #1;
    chk("reset ready_o", 32'(ready), 32'd0);
    chk("reset err_o", 32'(err), 32'd0);
    @(negedge clk_int);
    rst_ni = 1'b1;
    count_low(1, "reset scrub low cycles");

    for (int a = 0; a < NWORDS; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(NWORDS - 1 - a));
      step();
      chk("cleared rd0", rdata[0 +: DW], 32'h0);
    end

    // Write latency
    set_rd(0, 5'd5);
    set_rd(1, 5'd5);
    wr(0, 5'd5, 32'hDEADBEEF);
    step();
    idle();
    chk("x5 after 1 edge", rdata[0 +: DW], BYP ? 32'hDEADBEEF : 32'h0);
    step();
    chk("x5 after 2 edges", rdata[DW +: DW], 32'hDEADBEEF);

    for (int i = 0; i < 5; i++) begin
      set_rd(0, tbl[i].addr);
      wr(0, tbl[i].addr, tbl[i].data);
      step();
      idle();
      step();
      chk($sformatf("table %0d", i), rdata[0 +: DW], tbl[i].exp);
    end

    // Same-address collision
    set_rd(0, 5'd7);
    wr(0, 5'd7, 32'h1111);
    wr(1, 5'd7, 32'h2222);
    step();
    idle();
    chk("collision err_o", 32'(err), 32'd1);
    step();
    chk("collision x7", rdata[0 +: DW], 32'h1111);
    chk("collision err pulse", 32'(err), 32'd0);

    // Scrub with a pending write, plus a dropped write during scrub
    set_rd(0, 5'd3);
    set_rd(1, 5'd9);
    wr(0, 5'd3, 32'hA5);
    step();
    idle();
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    chk("scrub ready drop", 32'(ready), 32'd0);
    wr(0, 5'd9, 32'h77);
    step();
    idle();
    chk("write during scrub err", 32'(err), 32'd1);
    count_low(2, "scrub low cycles");
    step();
    chk("x3 after scrub", rdata[0 +: DW], 32'h0);
    chk("x9 dropped", rdata[DW +: DW], 32'h0);

    // Shadow r0
    dummy_instr = 1'b1;
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    wr(0, 5'd0, 32'h55);
    step();
    idle();
    step();
    chk("shadow r0 dummy=1", rdata[0 +: DW], 32'h55);
    dummy_instr = 1'b0;
    #1;
    chk("x0 dummy=0", rdata[DW +: DW], 32'h0);
    wr(0, 5'd0, 32'h99);
    step();
    idle();
    step();
    dummy_instr = 1'b1;
    #1;
    chk("x0 write discarded", rdata[0 +: DW], 32'h55);
    dummy_instr = 1'b0;

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      for (int w = 0; w < int'(NW); w++) begin
        we[w]             = ($urandom_range(0, 2) == 0);
        waddr[5*w +: 5]   = 5'($urandom_range(0, 7));
        wdata[DW*w +: DW] = $urandom;
      end
      for (int p = 0; p < int'(NR); p++) set_rd(p, 5'($urandom_range(0, 7)));
      dummy_instr = 1'($urandom_range(0, 1));
      scrub_req   = ($urandom_range(0, 63) == 0);
      step();
    end
    idle();
    dummy_instr = 1'b0;
    for (int i = 0; i < 40 && !ready; i++) step();
    chk("ready before mid-scrub reset", 32'(ready), 32'd1);

    // Reset in the middle of a scrub
    scrub_req = 1'b1;
    step();
    scrub_req = 1'b0;
    repeat (9) step();
    rst_ni = 1'b0;
    #1;
    chk("mid-scrub reset ready_o", 32'(ready), 32'd0);
    chk("mid-scrub reset err_o", 32'(err), 32'd0);
    model_reset();
    @(negedge clk_int);
    rst_ni = 1'b1;
    count_low(1, "rerun scrub low cycles");
    set_rd(0, 5'd7);
    set_rd(1, 5'd31);
    step();
    chk("x7 after rerun", rdata[0 +: DW], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
